// File: rtl/fdiv_prog_pkg.sv
// ---------------------------------------------------------------------------
// fdiv_prog_pkg
// Shared types and helpers for the programmable clock divider.
//   state_t : FSM encoding (IDLE, RUN, DRAIN)
//   eff_n() : decodes a ratio encoding into the effective divide ratio N
// ---------------------------------------------------------------------------
package fdiv_prog_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Widest supported counter. eff_n() works at this width and callers
    // narrow the result.
    localparam int MAX_WIDTH = 16;

    localparam logic [MAX_WIDTH:0] N_ONE = (MAX_WIDTH+1)'(1);
    localparam logic [MAX_WIDTH:0] N_MIN = (MAX_WIDTH+1)'(2);

    // Encoding 0 means 2^width. Encoding 1 is clamped to 2, because a
    // divide-by-1 cannot produce a registered low phase.
    function automatic logic [MAX_WIDTH:0] eff_n(input logic [MAX_WIDTH-1:0] enc,
                                                 input int                   width);
        logic [MAX_WIDTH:0] n;
        if (enc == '0) begin
            n = N_ONE << width;
        end else if (enc == MAX_WIDTH'(1)) begin
            n = N_MIN;
        end else begin
            n = {1'b0, enc};
        end
        return n;
    endfunction

endpackage

// File: rtl/fdiv_prog_if.sv
// ---------------------------------------------------------------------------
// fdiv_prog_if
// Ratio offer handshake between a ratio source and the divider.
//   ratio     : requested divide ratio encoding (0 = 2^WIDTH)
//   ratio_vld : source is offering a ratio
//   ratio_rdy : divider can accept the offer this cycle
// Modports: master (ratio source), slave (divider).
// ---------------------------------------------------------------------------
interface fdiv_prog_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] ratio;
    logic             ratio_vld;
    logic             ratio_rdy;

    modport master (output ratio, output ratio_vld, input ratio_rdy);
    modport slave  (input ratio, input ratio_vld, output ratio_rdy);
endinterface

// File: rtl/fdiv_prog_ratio_reg.sv
// ---------------------------------------------------------------------------
// fdiv_prog_ratio_reg
// Holds the active ratio encoding plus one pending ratio waiting for the next
// period boundary.
//   clk, rst         : clock, synchronous active-high reset
//   rbus (slave)     : ratio offer handshake; ratio_rdy = !pending
//   i_idle           : divider is in IDLE, offers take effect immediately
//   i_boundary       : current period ends (or is restarted) this cycle
//   o_cur_ratio      : encoding currently in effect
//   o_cur_ratio_nx   : encoding that will be in effect next cycle
// ---------------------------------------------------------------------------
module fdiv_prog_ratio_reg #(
    parameter int WIDTH      = 4,
    parameter int INIT_RATIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    fdiv_prog_if.slave       rbus,
    input  logic             i_idle,
    input  logic             i_boundary,
    output logic [WIDTH-1:0] o_cur_ratio,
    output logic [WIDTH-1:0] o_cur_ratio_nx
);

    logic             r_pending;
    logic [WIDTH-1:0] r_pend_ratio;
    logic [WIDTH-1:0] r_cur_ratio;

    logic             w_accept;
    logic             w_pending_nx;
    logic [WIDTH-1:0] w_pend_nx;
    logic [WIDTH-1:0] w_cur_nx;

    assign rbus.ratio_rdy = !r_pending;
    assign w_accept       = rbus.ratio_vld && !r_pending;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_pending_nx = r_pending;
        w_pend_nx    = r_pend_ratio;
        w_cur_nx     = r_cur_ratio;

        // A pending ratio is normally consumed at a boundary. It can also be
        // seen in IDLE when it was accepted on the very edge that ended a
        // drain; it is applied straight away so the handshake never stalls.
        if (r_pending && (i_idle || i_boundary)) begin
            w_cur_nx     = r_pend_ratio;
            w_pending_nx = 1'b0;
        end

        // Acceptance needs !pending, so it never collides with the apply
        // above. An offer taken in the boundary cycle itself is parked and
        // waits for the following boundary.
        if (w_accept) begin
            if (i_idle) begin
                w_cur_nx = rbus.ratio;
            end else begin
                w_pending_nx = 1'b1;
                w_pend_nx    = rbus.ratio;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= 1'b0;
            r_pend_ratio <= '0;
            r_cur_ratio  <= WIDTH'(INIT_RATIO);
        end else begin
            r_pending    <= w_pending_nx;
            r_pend_ratio <= w_pend_nx;
            r_cur_ratio  <= w_cur_nx;
        end
    end

    assign o_cur_ratio    = r_cur_ratio;
    assign o_cur_ratio_nx = w_cur_nx;

endmodule

// File: rtl/fdiv_prog.sv
// ---------------------------------------------------------------------------
// fdiv_prog
// Programmable clock divider with a glitch-free registered output, a
// period-end tick, and a ratio handshake that only changes the ratio at
// period boundaries.
//   clk, rst     : clock, synchronous active-high reset
//   en           : run request (IDLE -> RUN, RUN -> DRAIN when dropped)
//   sync         : phase restart, present only with FDIV_PROG_SYNC_EN
//   rbus (slave) : ratio offer handshake (ratio, ratio_vld, ratio_rdy)
//   out          : divided clock, low floor(N/2) cycles, high ceil(N/2)
//   tick         : one-cycle pulse in the last cycle of each period
//   cur_ratio    : ratio encoding currently in effect
// Optional feature macro: FDIV_PROG_SYNC_EN.
// Legal WIDTH range is 2..16.
// ---------------------------------------------------------------------------
module fdiv_prog
    import fdiv_prog_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int INIT_RATIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef FDIV_PROG_SYNC_EN
    input  logic             sync,
`endif
    fdiv_prog_if.slave       rbus,
    output logic             out,
    output logic             tick,
    output logic [WIDTH-1:0] cur_ratio
);

    // N needs one extra bit to hold 2^WIDTH.
    localparam int NW = WIDTH + 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_out;
    logic             r_tick;

    state_t           w_state_nx;
    logic [WIDTH-1:0] w_cnt_nx;
    logic [WIDTH-1:0] w_cur_ratio;
    logic [WIDTH-1:0] w_cur_ratio_nx;
    logic [NW-1:0]    w_n;
    logic [NW-1:0]    w_n_nx;
    logic             w_last;
    logic             w_sync;
    logic             w_idle;
    logic             w_boundary;

    // sync only acts while a period is running; in IDLE it is ignored.
`ifdef FDIV_PROG_SYNC_EN
    assign w_sync = sync && (r_state != IDLE);
`else
    assign w_sync = 1'b0;
`endif

    assign w_idle     = (r_state == IDLE);
    assign w_n        = NW'(eff_n(MAX_WIDTH'(w_cur_ratio), WIDTH));
    assign w_n_nx     = NW'(eff_n(MAX_WIDTH'(w_cur_ratio_nx), WIDTH));
    assign w_last     = ({1'b0, r_cnt} == (w_n - NW'(1)));
    assign w_boundary = !w_idle && (w_last || w_sync);

    fdiv_prog_ratio_reg #(
        .WIDTH      (WIDTH),
        .INIT_RATIO (INIT_RATIO)
    ) u_ratio_reg (
        .clk            (clk),
        .rst            (rst),
        .rbus           (rbus),
        .i_idle         (w_idle),
        .i_boundary     (w_boundary),
        .o_cur_ratio    (w_cur_ratio),
        .o_cur_ratio_nx (w_cur_ratio_nx)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (en) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                w_cnt_nx = w_last ? '0 : r_cnt + 1'b1;
                // Dropping en in the last cycle means the period is already
                // complete, so there is nothing left to drain.
                if (!en) begin
                    w_state_nx = w_last ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                w_cnt_nx = w_last ? '0 : r_cnt + 1'b1;
                if (en) begin
                    w_state_nx = RUN;
                end else if (w_last) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
        if (w_sync) begin
            w_cnt_nx = '0;
        end
    end

    // out and tick are computed from next-cycle count and ratio so they line
    // up with r_cnt. With cnt = 0 both are always 0 (N >= 2), so a sync
    // restart or a ratio switch can never glitch the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_out   <= (w_state_nx != IDLE) && ({1'b0, w_cnt_nx} >= (w_n_nx >> 1));
            r_tick  <= (w_state_nx != IDLE) && ({1'b0, w_cnt_nx} == (w_n_nx - NW'(1)));
        end
    end

    assign out       = r_out;
    assign tick      = r_tick;
    assign cur_ratio = w_cur_ratio;

endmodule

// File: tb/tb_fdiv_prog.sv
// ---------------------------------------------------------------------------
// tb_fdiv_prog
// Self-checking bench for fdiv_prog. Directed stimulus pushes one expected
// record per output period (period length, high-phase length, ratio in
// effect) into a queue; a monitor pops a record on every tick and compares.
// Handshake, IDLE and reset behaviour are checked directly by the stimulus.
// A second instance with WIDTH=3 covers the encoding-0 decode at that width.
// Honours FDIV_PROG_SYNC_EN for the optional sync port.
// ---------------------------------------------------------------------------
module tb_fdiv_prog;

    typedef struct {
        int         len;   // 0: first period after IDLE, length not checked
        int         hi;
        logic [3:0] cur;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       out;
    logic       tick;
    logic [3:0] cur_ratio;
    logic       en3;
    logic       out3;
    logic       tick3;
    logic [2:0] cur_ratio3;
`ifdef FDIV_PROG_SYNC_EN
    logic       sync;
    logic       sync3;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    fdiv_prog_if #(.WIDTH(4)) rb ();
    fdiv_prog_if #(.WIDTH(3)) rb3 ();

    fdiv_prog #(.WIDTH(4), .INIT_RATIO(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
`ifdef FDIV_PROG_SYNC_EN
        .sync      (sync),
`endif
        .rbus      (rb),
        .out       (out),
        .tick      (tick),
        .cur_ratio (cur_ratio)
    );

    fdiv_prog #(.WIDTH(3), .INIT_RATIO(0)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .en        (en3),
`ifdef FDIV_PROG_SYNC_EN
        .sync      (sync3),
`endif
        .rbus      (rb3),
        .out       (out3),
        .tick      (tick3),
        .cur_ratio (cur_ratio3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges, then step off the edge to drive inputs.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int len, input int hi, input logic [3:0] cur);
        exp_t e;
        e.len = len;
        e.hi  = hi;
        e.cur = cur;
        exp_q.push_back(e);
    endtask

    // Accept a ratio while the DUT is IDLE.
    task automatic load_idle(input logic [3:0] r);
        rb.ratio     = r;
        rb.ratio_vld = 1'b1;
        wait_cyc(1);
        rb.ratio_vld = 1'b0;
        @(negedge clk);
        check("idle_load_cur_ratio", cur_ratio, r);
    endtask

    // Monitor: measures period and high-phase lengths, pops on every tick.
    int m_len = 0;
    int m_hi  = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_len = 0;
                m_hi  = 0;
            end else begin
                m_len++;
                if (out) m_hi++;
                else     m_hi = 0;
                if (tick) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tick: got tick expected none (t=%0t)", $time);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (e.len != 0) check("period_len", m_len, e.len);
                        check("high_len", m_hi, e.hi);
                        check("tick_cur_ratio", cur_ratio, e.cur);
                    end
                    m_len = 0;
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        en3           = 1'b0;
        rb.ratio      = '0;
        rb.ratio_vld  = 1'b0;
        rb3.ratio     = '0;
        rb3.ratio_vld = 1'b0;
`ifdef FDIV_PROG_SYNC_EN
        sync          = 1'b0;
        sync3         = 1'b0;
`endif

        // Reset state
        wait_cyc(3);
        @(negedge clk);
        check("rst_out", out, 0);
        check("rst_tick", tick, 0);
        check("rst_ratio_rdy", rb.ratio_rdy, 1);
        check("rst_cur_ratio", cur_ratio, 0);
        wait_cyc(1);
        rst = 1'b0;

        // N=16 free run, drain with en re-raised at cnt=10, then a full drain
        en = 1'b1;
        push(0, 8, 0);
        wait_cyc(1);                 // cnt0 of period 1
        push(16, 8, 0);
        push(16, 8, 0);
        wait_cyc(48);                // cnt0 of period 4
        push(16, 8, 0);
        wait_cyc(4);  en = 1'b0;     // drop at cnt4
        wait_cyc(6);  en = 1'b1;     // re-raise at cnt10
        wait_cyc(6);                 // cnt0 of period 5
        push(16, 8, 0);
        wait_cyc(4);  en = 1'b0;     // drop at cnt4, drain to cnt15
        wait_cyc(12);                // first IDLE cycle
        @(negedge clk);
        check("drain_idle_out", out, 0);
        check("drain_idle_tick", tick, 0);
        wait_cyc(3);
        @(negedge clk);
        check("idle_out_hold", out, 0);

        // ratio=5 loaded in IDLE; ratio=7 accepted on a boundary cycle
        @(negedge clk);
        check("idle_rdy", rb.ratio_rdy, 1);
        load_idle(4'd5);
        wait_cyc(1);
        en = 1'b1;
        push(0, 3, 5);
        push(5, 3, 5);
        wait_cyc(1);                 // cnt0 of period 1
        wait_cyc(4);                 // cnt4, boundary cycle
        rb.ratio     = 4'd7;
        rb.ratio_vld = 1'b1;
        wait_cyc(1);                 // cnt0 of period 2
        rb.ratio_vld = 1'b0;
        push(7, 4, 7);
        @(negedge clk);
        check("bnd_accept_cur_unchanged", cur_ratio, 5);
        check("bnd_accept_pending", rb.ratio_rdy, 0);
        wait_cyc(5);                 // cnt0 of period 3
        en = 1'b0;
        @(negedge clk);
        check("bnd_accept_applied", cur_ratio, 7);
        check("bnd_pending_cleared", rb.ratio_rdy, 1);
        wait_cyc(7);                 // IDLE

        // N=16, ratio=6 offered at cnt3, second offer stalled while pending
        load_idle(4'd0);
        wait_cyc(1);
        en = 1'b1;
        push(0, 8, 0);
        wait_cyc(1);                 // cnt0 of period 1
        push(16, 8, 0);
        wait_cyc(16);                // cnt0 of period 2
        wait_cyc(3);                 // cnt3
        rb.ratio     = 4'd6;
        rb.ratio_vld = 1'b1;
        @(negedge clk);
        check("offer_rdy", rb.ratio_rdy, 1);
        wait_cyc(1);                 // cnt4, 6 now pending
        push(6, 3, 6);
        rb.ratio = 4'd9;             // second offer, held valid
        @(negedge clk);
        check("pend_rdy_low", rb.ratio_rdy, 0);
        check("pend_cur_hold", cur_ratio, 0);
        wait_cyc(11);                // cnt15, boundary
        @(negedge clk);
        check("pend_rdy_low_bnd", rb.ratio_rdy, 0);
        check("pend_cur_hold_bnd", cur_ratio, 0);
        wait_cyc(1);                 // cnt0 of period 3 (N=6)
        @(negedge clk);
        check("applied_cur", cur_ratio, 6);
        check("applied_rdy", rb.ratio_rdy, 1);
        wait_cyc(1);                 // cnt1, 9 now pending
        rb.ratio_vld = 1'b0;
        push(9, 5, 9);
        @(negedge clk);
        check("second_pend_rdy", rb.ratio_rdy, 0);
        wait_cyc(5);                 // cnt0 of period 4 (N=9)
        en = 1'b0;
        @(negedge clk);
        check("second_applied_cur", cur_ratio, 9);
        wait_cyc(9);                 // IDLE

        // ratio=1 clamps to N=2
        load_idle(4'd1);
        wait_cyc(1);
        en = 1'b1;
        push(0, 1, 1);
        push(2, 1, 1);
        push(2, 1, 1);
        push(2, 1, 1);
        wait_cyc(1);                 // cnt0 of period 1
        @(negedge clk);
        check("n2_out_low", out, 0);
        wait_cyc(1);
        @(negedge clk);
        check("n2_out_high", out, 1);
        wait_cyc(5);                 // cnt0 of period 4
        en = 1'b0;
        wait_cyc(2);                 // IDLE

        // WIDTH=3, encoding 0 -> N=8
        en3 = 1'b1;
        wait_cyc(1);                 // cnt0
        @(negedge clk);
        check("w3_cur_ratio", cur_ratio3, 0);
        check("w3_cnt0_out", out3, 0);
        check("w3_cnt0_tick", tick3, 0);
        wait_cyc(3);
        @(negedge clk);
        check("w3_cnt3_out", out3, 0);
        wait_cyc(1);
        @(negedge clk);
        check("w3_cnt4_out", out3, 1);
        wait_cyc(3);
        @(negedge clk);
        check("w3_cnt7_tick", tick3, 1);
        wait_cyc(1);
        en3 = 1'b0;
        @(negedge clk);
        check("w3_wrap_tick", tick3, 0);
        check("w3_wrap_out", out3, 0);
        wait_cyc(8);
        @(negedge clk);
        check("w3_idle_out", out3, 0);

        // Reset at cnt9 with en held and a ratio pending: no tick, all reset
        load_idle(4'd0);
        wait_cyc(1);
        en = 1'b1;
        wait_cyc(1);                 // cnt0
        wait_cyc(2);                 // cnt2
        rb.ratio     = 4'd12;
        rb.ratio_vld = 1'b1;
        wait_cyc(1);                 // cnt3
        rb.ratio_vld = 1'b0;
        @(negedge clk);
        check("pre_rst_pending", rb.ratio_rdy, 0);
        wait_cyc(6);                 // cnt9
        @(negedge clk);
        check("pre_rst_out", out, 1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        check("mid_rst_out", out, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_rdy", rb.ratio_rdy, 1);
        check("mid_rst_cur", cur_ratio, 0);
        wait_cyc(20);
        @(negedge clk);
        check("post_rst_idle_out", out, 0);

`ifdef FDIV_PROG_SYNC_EN
        // sync at cnt7 restarts the period; sync in IDLE is ignored
        en = 1'b1;
        push(0, 8, 0);
        push(24, 8, 0);
        wait_cyc(1);                 // cnt0 of period 1
        wait_cyc(16);                // cnt0 of period 2
        wait_cyc(7);                 // cnt7
        sync = 1'b1;
        wait_cyc(1);                 // restarted at cnt0
        sync = 1'b0;
        en   = 1'b0;
        @(negedge clk);
        check("sync_out", out, 0);
        check("sync_tick", tick, 0);
        wait_cyc(16);                // IDLE
        sync = 1'b1;
        wait_cyc(3);
        @(negedge clk);
        check("sync_idle_out", out, 0);
        check("sync_idle_tick", tick, 0);
        sync = 1'b0;
`endif

        wait_cyc(5);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
